// File: rtl/cpu_io_pkg.sv
// rtl/cpu_io_pkg.sv - shared CPU I/O port constants and helpers
package cpu_io_pkg;

    localparam int IO_DATA_W     = 8;
    localparam int IO_FIFO_DEPTH = 4;

    // Ceiling log2; used for pointer and count widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/inpr_fifo.sv
// rtl/inpr_fifo.sv - input-port byte FIFO: storage, pointers, count
// Ports: clk/rst_n; push+wdata write at wr_ptr when not full; pop advances
// rd_ptr when not empty; rdata is the raw head entry; count/full/empty status.
module inpr_fifo
    import cpu_io_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W,
    parameter int DEPTH  = IO_FIFO_DEPTH,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Both qualifiers use the pre-edge count, so a push on a full FIFO is
    // refused even when a pop frees a slot on the same edge.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; empty gating hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inpr_port.sv
// rtl/inpr_port.sv - CPU input port: device FIFO, FGI, IEN, irq, overrun
// Ports: device side dev_data/dev_stb/dev_ready; CPU side rd/data_out/FGI;
// interrupt control ien_set/ien_clr/irq_ack -> IEN/irq; overrun/ovr_clr.
module inpr_port
    import cpu_io_pkg::*;
#(
    parameter int DATA_W = IO_DATA_W,
    parameter int DEPTH  = IO_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] dev_data,
    input  logic              dev_stb,
    output logic              dev_ready,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out,
    output logic              FGI,
    input  logic              ien_set,
    input  logic              ien_clr,
    input  logic              irq_ack,
    output logic              IEN,
    output logic              irq,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int CW = clog2(DEPTH) + 1;

    logic [DATA_W-1:0] head;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              drop;

    inpr_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (dev_stb),
        .pop   (rd),
        .wdata (dev_data),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign drop      = dev_stb & full;
    assign FGI       = ~empty;
    assign dev_ready = ~full;
    assign data_out  = FGI ? head : '0;
    assign irq       = IEN & FGI;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IEN     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            // Clearing sources beat ien_set so an acknowledged interrupt
            // cannot be re-armed on the same edge.
            if (ien_clr | irq_ack) begin
                IEN <= 1'b0;
            end else if (ien_set) begin
                IEN <= 1'b1;
            end
            // A fresh drop outranks ovr_clr so no loss goes unreported.
            if (drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_inpr_port.sv
// tb/tb_inpr_port.sv - scoreboard bench for inpr_port
module tb_inpr_port;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dev_data;
    logic       dev_stb;
    logic       dev_ready;
    logic       rd;
    logic [7:0] data_out;
    logic       FGI;
    logic       ien_set;
    logic       ien_clr;
    logic       irq_ack;
    logic       IEN;
    logic       irq;
    logic       overrun;
    logic       ovr_clr;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    inpr_port dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dev_data  (dev_data),
        .dev_stb   (dev_stb),
        .dev_ready (dev_ready),
        .rd        (rd),
        .data_out  (data_out),
        .FGI       (FGI),
        .ien_set   (ien_set),
        .ien_clr   (ien_clr),
        .irq_ack   (irq_ack),
        .IEN       (IEN),
        .irq       (irq),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs set 1 time unit after a rising edge; they act on the next edge.
    task automatic step(input logic stb, input logic [7:0] d, input logic r,
                        input logic iset, input logic iclr, input logic iack,
                        input logic oclr);
        @(posedge clk);
        #1;
        dev_stb  = stb;
        dev_data = d;
        rd       = r;
        ien_set  = iset;
        ien_clr  = iclr;
        irq_ack  = iack;
        ovr_clr  = oclr;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic strobe(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Issue a pop and register the head byte the scoreboard should see.
    task automatic pop_exp(input logic [7:0] e);
        exp_q.push_back(e);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: a pop is presented whenever rd is high at the falling edge.
    always @(negedge clk) begin
        if (rst_n && rd) begin
            if (FGI) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pop: got %h expected no data", data_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (data_out !== e) begin
                        errors++;
                        $display("FAIL pop_data: got %h expected %h at %0t", data_out, e, $time);
                    end
                end
            end else if (exp_q.size() != 0) begin
                logic [7:0] e;
                checks++;
                errors++;
                e = exp_q.pop_front();
                $display("FAIL pop_empty: got FGI=0 expected byte %h at %0t", e, $time);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; dev_stb = 1'b0; dev_data = 8'h00; rd = 1'b0;
        ien_set = 1'b0; ien_clr = 1'b0; irq_ack = 1'b0; ovr_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle();
        chk("rst_fgi", {7'd0, FGI}, 8'd0);
        chk("rst_data", data_out, 8'h00);
        chk("rst_ready", {7'd0, dev_ready}, 8'd1);
        chk("rst_ien", {7'd0, IEN}, 8'd0);
        chk("rst_irq", {7'd0, irq}, 8'd0);
        chk("rst_ovr", {7'd0, overrun}, 8'd0);

        // Single byte round trip
        strobe(8'h41);
        idle();
        chk("t2_fgi", {7'd0, FGI}, 8'd1);
        chk("t2_data", data_out, 8'h41);
        idle();
        pop_exp(8'h41);
        idle();
        chk("t2_fgi_after", {7'd0, FGI}, 8'd0);
        chk("t2_data_after", data_out, 8'h00);

        // Fill, overflow, drain
        strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44);
        strobe(8'h55);
        chk("t3_ready_full", {7'd0, dev_ready}, 8'd0);
        chk("t3_ovr_pre", {7'd0, overrun}, 8'd0);
        idle();
        chk("t3_ovr_set", {7'd0, overrun}, 8'd1);
        pop_exp(8'h11); pop_exp(8'h22); pop_exp(8'h33); pop_exp(8'h44);
        idle();
        chk("t3_fgi_drained", {7'd0, FGI}, 8'd0);
        chk("t3_ovr_sticky", {7'd0, overrun}, 8'd1);
        chk("t3_ready", {7'd0, dev_ready}, 8'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("t3_ovr_clr", {7'd0, overrun}, 8'd0);

        // Full FIFO: strobe and pop on the same edge
        strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44);
        exp_q.push_back(8'h11);
        step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("t4_ovr", {7'd0, overrun}, 8'd1);
        chk("t4_ready", {7'd0, dev_ready}, 8'd1);
        chk("t4_head", data_out, 8'h22);
        pop_exp(8'h22); pop_exp(8'h33); pop_exp(8'h44);
        idle();
        chk("t4_empty", {7'd0, FGI}, 8'd0);
        // drop vs ovr_clr on the same edge: drop wins
        strobe(8'h01); strobe(8'h02); strobe(8'h03); strobe(8'h04);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("t4_drop_wins", {7'd0, overrun}, 8'd1);
        pop_exp(8'h01); pop_exp(8'h02); pop_exp(8'h03); pop_exp(8'h04);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("t4_ovr_clr", {7'd0, overrun}, 8'd0);

        // Interrupt flag
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        strobe(8'h7F);
        idle();
        chk("t5_ien", {7'd0, IEN}, 8'd1);
        chk("t5_irq", {7'd0, irq}, 8'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        chk("t5_ack_ien", {7'd0, IEN}, 8'd0);
        chk("t5_ack_irq", {7'd0, irq}, 8'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        chk("t5_clr_wins", {7'd0, IEN}, 8'd0);
        pop_exp(8'h7F);
        idle();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("t5_empty_rd_fgi", {7'd0, FGI}, 8'd0);
        chk("t5_empty_rd_data", data_out, 8'h00);
        chk("t5_empty_rd_ovr", {7'd0, overrun}, 8'd0);
        chk("t5_empty_rd_ready", {7'd0, dev_ready}, 8'd1);

        // Asynchronous reset mid-stream
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        strobe(8'h01); strobe(8'h02); strobe(8'h03);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_fgi", {7'd0, FGI}, 8'd0);
        chk("t6_data", data_out, 8'h00);
        chk("t6_ien", {7'd0, IEN}, 8'd0);
        chk("t6_irq", {7'd0, irq}, 8'd0);
        @(posedge clk);
        #1;
        dev_stb = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        strobe(8'h9A);
        idle();
        chk("t6_head", data_out, 8'h9A);
        pop_exp(8'h9A);
        idle();
        chk("t6_fgi_end", {7'd0, FGI}, 8'd0);
        chk("t6_ready_end", {7'd0, dev_ready}, 8'd1);

        idle();
        chk("sb_drained", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
